// File: rtl/id_token_stats.sv
// Identifier token statistics: reports digit-terminated identifiers seen on the
// recognizer's character stream. Optional max-length tracking via ID_STATS_MAXLEN_EN.
module id_token_stats #(
  parameter int CNT_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic             id_hit,
  output logic             tok_valid,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] tok_count,
  output logic [LEN_W-1:0] max_len
);

  typedef enum logic {IDLE, IN_TOK} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       char_d_reg;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             last_hit_reg, last_hit_next;
  logic             report_next;
  logic             tok_valid_reg;
  logic [LEN_W-1:0] tok_len_reg;
  logic [CNT_W-1:0] tok_count_reg;

  logic is_letter, is_digit, is_alnum;

  // Classes are taken from the delayed char so they line up with id_hit.
  always_comb begin
    is_letter = ((char_d_reg >= 8'd65) && (char_d_reg <= 8'd90)) ||
                ((char_d_reg >= 8'd97) && (char_d_reg <= 8'd122));
    is_digit  = (char_d_reg >= 8'd48) && (char_d_reg <= 8'd57);
    is_alnum  = is_letter || is_digit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (is_letter) state_next = IN_TOK;
      IN_TOK:  if (!is_alnum) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    len_next      = len_reg;
    last_hit_next = last_hit_reg;
    report_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_letter) begin
          len_next      = LEN_W'(1);
          last_hit_next = id_hit;
        end
      end
      IN_TOK: begin
        if (is_alnum) begin
          len_next      = (len_reg == {LEN_W{1'b1}}) ? len_reg : len_reg + LEN_W'(1);
          last_hit_next = id_hit;
        end else begin
          report_next = last_hit_reg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_d_reg    <= 8'd0;
      len_reg       <= '0;
      last_hit_reg  <= 1'b0;
      tok_valid_reg <= 1'b0;
      tok_len_reg   <= '0;
      tok_count_reg <= '0;
    end else begin
      char_d_reg    <= char;
      len_reg       <= len_next;
      last_hit_reg  <= last_hit_next;
      tok_valid_reg <= report_next;
      if (report_next) begin
        tok_len_reg   <= len_reg;
        tok_count_reg <= tok_count_reg + CNT_W'(1);
      end
    end
  end

`ifdef ID_STATS_MAXLEN_EN
  logic [LEN_W-1:0] max_len_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_len_reg <= '0;
    end else if (report_next && (len_reg > max_len_reg)) begin
      max_len_reg <= len_reg;
    end
  end

  assign max_len = max_len_reg;
`else
  assign max_len = '0;
`endif

  assign tok_valid = tok_valid_reg;
  assign tok_len   = tok_len_reg;
  assign tok_count = tok_count_reg;

endmodule

// File: tb/tb_id_token_stats.sv
// Bench for id_token_stats: string-level token model checked every cycle,
// plus literal expectations per directed stream.
module tb_id_token_stats;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char = 8'd32;
  logic       id_hit = 1'b0;
  logic       tok_valid;
  logic [7:0] tok_len;
  logic [15:0] tok_count;
  logic [7:0] max_len;

  id_token_stats #(.CNT_W(16), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .char(char), .id_hit(id_hit),
    .tok_valid(tok_valid), .tok_len(tok_len), .tok_count(tok_count), .max_len(max_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // token model (string level)
  bit in_tok = 0;
  bit ends_digit = 0;
  int cur_len = 0;
  int report_at[int];
  // recognizer model producing id_hit (never reset by the block)
  bit rec_in = 0;
  bit pend_hit = 0;
  // expected outputs and observation bookkeeping
  int cyc = 0;
  int e_len = 0, e_cnt = 0, e_max = 0;
  int pulses = 0, last_pulse = -100, last_gap = 0;

  function automatic bit is_letter(input logic [7:0] c);
    return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
  endfunction
  function automatic bit is_digit(input logic [7:0] c);
    return c >= 48 && c <= 57;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, sampled after the falling edge.
  task automatic step_check();
    bit ev;
    cyc++;
    ev = report_at.exists(cyc);
    if (ev) begin
      e_len = report_at[cyc];
      e_cnt = (e_cnt + 1) % 65536;
`ifdef ID_STATS_MAXLEN_EN
      if (e_len > e_max) e_max = e_len;
`endif
      pulses++;
      last_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    chk("tok_valid", int'(tok_valid), int'(ev));
    chk("tok_len", int'(tok_len), e_len);
    chk("tok_count", int'(tok_count), e_cnt);
    chk("max_len", int'(max_len), e_max);
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    step_check();
    // token rules applied to the raw character
    if (!in_tok) begin
      if (is_letter(c)) begin
        in_tok = 1; cur_len = 1; ends_digit = 0;
      end
    end else if (is_letter(c) || is_digit(c)) begin
      cur_len++; ends_digit = is_digit(c);
    end else begin
      if (ends_digit) report_at[cyc + 2] = (cur_len > 255) ? 255 : cur_len;
      in_tok = 0;
    end
    char = c;
    id_hit = pend_hit;
    if (is_letter(c)) begin
      rec_in = 1; pend_hit = 0;
    end else if (is_digit(c)) begin
      pend_hit = rec_in;
    end else begin
      rec_in = 0; pend_hit = 0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic flush();
    repeat (3) send(8'd32);
  endtask

  task automatic clear_model();
    in_tok = 0; ends_digit = 0; cur_len = 0;
    report_at.delete();
    e_len = 0; e_cnt = 0; e_max = 0;
  endtask

  // Reset asserted and released between edges; optionally checks outputs while held.
  task automatic pulse_reset(input bit check_now);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    if (check_now) begin
      chk("async_rst_valid", int'(tok_valid), 0);
      chk("async_rst_len", int'(tok_len), 0);
      chk("async_rst_count", int'(tok_count), 0);
      chk("async_rst_max", int'(max_len), 0);
    end
    clear_model();
    #1 reset = 1'b0;
  endtask

  int p0;
  int exp_max_final;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", int'(tok_valid), 0);
    chk("reset_len", int'(tok_len), 0);
    chk("reset_count", int'(tok_count), 0);
    chk("reset_max", int'(max_len), 0);
    reset = 1'b0;

    // ab12 -> one report of length 4
    p0 = pulses;
    send_str("ab12 "); flush();
    chk("t1_pulses", pulses - p0, 1);
    chk("t1_len", int'(tok_len), 4);
    chk("t1_count", int'(tok_count), 1);

    // ab1c not reported, x9 reported
    pulse_reset(0);
    p0 = pulses;
    send_str("ab1c;x9 "); flush();
    chk("t2_pulses", pulses - p0, 1);
    chk("t2_len", int'(tok_len), 2);
    chk("t2_count", int'(tok_count), 1);

    // leading digits ignored, two reports
    pulse_reset(0);
    p0 = pulses;
    send_str("99a7,b3."); flush();
    chk("t3_pulses", pulses - p0, 2);
    chk("t3_len", int'(tok_len), 2);
    chk("t3_count", int'(tok_count), 2);
    chk("t3_gap_ge2", int'(last_gap >= 2), 1);

    // length saturation
    pulse_reset(0);
    send(8'd97);
    repeat (299) send(8'd49);
    send(8'd32); flush();
    chk("t4_len_sat", int'(tok_len), 255);
    chk("t4_count", int'(tok_count), 1);

    // asynchronous reset mid-token
    pulse_reset(0);
    send_str("x5 "); flush();
    chk("t5_pre_count", int'(tok_count), 1);
    send_str("ab1");
    pulse_reset(1);
    p0 = pulses;
    send_str("2 "); flush();
    chk("t5_no_pulse", pulses - p0, 0);
    send_str("c5 "); flush();
    chk("t5_len", int'(tok_len), 2);
    chk("t5_count", int'(tok_count), 1);

    // max length tracking
    pulse_reset(0);
    send_str("a1 ab12 x3 "); flush();
`ifdef ID_STATS_MAXLEN_EN
    exp_max_final = 4;
`else
    exp_max_final = 0;
`endif
    chk("t6_max", int'(max_len), exp_max_final);
    chk("t6_count", int'(tok_count), 3);
    chk("t6_len", int'(tok_len), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
